// File: rtl/fifo_uart_tx_if.sv
// FIFO read port plus serial-line outputs of the UART transmit drain stage.
interface fifo_uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  tx_enable;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_d_out;
    logic                  fifo_rd_en;
    logic                  tx;
    logic                  busy;
    logic                  frame_done;

    modport master (
        input  tx_enable,
        input  fifo_empty,
        input  fifo_d_out,
        output fifo_rd_en,
        output tx,
        output busy,
        output frame_done
    );

    modport slave (
        output tx_enable,
        output fifo_empty,
        output fifo_d_out,
        input  fifo_rd_en,
        input  tx,
        input  busy,
        input  frame_done
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the synchronous FIFO and serialises them as UART frames.
// Outputs are decoded purely from registered state.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input logic              clk,
    input logic              rst_n,
    fifo_uart_tx_if.master   bus
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic          PAR_INV   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
    } state_t;

    state_t                state;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [BW-1:0]         bit_q;
    logic [CW-1:0]         baud_q;
    logic                  par_q;
    logic                  baud_tc;
    logic                  last_bit;
    logic                  last_stop;

    assign baud_tc   = (baud_q == BAUD_LAST);
    assign last_bit  = (bit_q == DATA_LAST);
    assign last_stop = (bit_q == STOP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (bus.tx_enable && !bus.fifo_empty) state_d = FETCH;
            FETCH:   state_d = LOAD;
            LOAD:    state_d = START;
            START:   if (baud_tc) state_d = DATA;
            DATA:    if (baud_tc && last_bit)
                         state_d = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (baud_tc) state_d = STOP;
            STOP:    if (baud_tc && last_stop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // bit_q counts data bits in DATA and stop bits in STOP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            bit_q   <= '0;
            baud_q  <= '0;
            par_q   <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    shift_q <= bus.fifo_d_out;
                    par_q   <= (^bus.fifo_d_out) ^ PAR_INV;
                    baud_q  <= '0;
                    bit_q   <= '0;
                end
                START, DATA, PARITY, STOP: begin
                    baud_q <= baud_tc ? '0 : baud_q + 1'b1;
                    if (baud_tc && state == DATA) begin
                        shift_q <= shift_q >> 1;
                        bit_q   <= last_bit ? '0 : bit_q + 1'b1;
                    end
                    if (baud_tc && state == STOP) bit_q <= bit_q + 1'b1;
                end
                default: begin
                    baud_q <= '0;
                    bit_q  <= '0;
                end
            endcase
        end
    end

    assign bus.fifo_rd_en = (state == FETCH);
    assign bus.busy       = (state != IDLE);
    assign bus.frame_done = (state == STOP) && baud_tc && last_stop;
    assign bus.tx = (state == START)  ? 1'b0 :
                    (state == DATA)   ? shift_q[0] :
                    (state == PARITY) ? par_q : 1'b1;
endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream drain stage for the 8-bit synchronous FIFO.
- Pops one byte at a time through the FIFO's read port (rd_en / empty / registered d_out) and serialises it as an asynchronous UART frame.
- Frame format: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
- Runs in the same clk domain as the FIFO. The FIFO sees it as its only reader.

Parameters:
- DATA_WIDTH, 8, byte width; must equal the FIFO width.
- CLKS_PER_BIT, 16, clk cycles per UART bit; legal range >= 2.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_enable  input  1  permits new frames to start; sampled in IDLE only.
- fifo_empty  input  1  FIFO empty flag.
- fifo_d_out  input  DATA_WIDTH  FIFO read data; valid the cycle after fifo_rd_en.
- fifo_rd_en  output  1  one-cycle FIFO pop strobe.
- tx  output  1  serial line; idle high.
- busy  output  1  high in every state except IDLE.
- frame_done  output  1  one-cycle pulse at the end of the last stop bit.

Behaviour:
- Reset is clk (rising edge) plus rst_n (asynchronous, active-low). On reset assertion:
  - state=IDLE, tx=1, fifo_rd_en=0, busy=0, frame_done=0.
  - Shift register, bit counter and baud counter all cleared.
- All outputs are registered or decoded from registered state; no combinational path from any input to any output.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - If tx_enable=1 and fifo_empty=0, go to FETCH; otherwise stay.
- FETCH (exactly 1 cycle):
  - fifo_rd_en=1, go to LOAD.
  - This is the only state that drives fifo_rd_en, so at most one pop per frame.
  - Reads are never issued on consecutive cycles, which keeps the FIFO's one-cycle-late registered empty flag safe.
- LOAD (exactly 1 cycle):
  - Capture fifo_d_out into the shift register.
  - Compute the parity bit: XOR of data bits, inverted if PARITY_ODD.
  - Clear the baud counter and go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx = shift_reg[0] for CLKS_PER_BIT cycles per bit, LSB first.
  - Shift right after each bit.
  - After DATA_WIDTH bits, go to PARITY if PARITY_EN, else STOP.
- PARITY: tx = parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - frame_done=1 on the final cycle of this state, then go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT); bit boundary at terminal count.
- Bit counter: width $clog2(DATA_WIDTH+1).
- Frame period, back-to-back with the FIFO non-empty: 3 + CLKS_PER_BIT*(1+DATA_WIDTH+PARITY_EN+STOP_BITS) cycles.
  - The IDLE/FETCH/LOAD cycles hold tx=1 and act as extra stop time.
- tx_enable dropped mid-frame: current frame completes normally; no new FETCH until tx_enable=1 again.
- fifo_empty rising after FETCH: ignored; the popped byte is always transmitted.
- FIFO empty in IDLE: block stays in IDLE and fifo_rd_en is never asserted. Underflow is therefore impossible by construction.
- Reset mid-frame:
  - tx returns high immediately (asynchronous).
  - The byte already popped is discarded; no partial-frame recovery.

Test Plan:
1. CLKS_PER_BIT=4, PARITY_EN=0, STOP_BITS=1; FIFO holds 0xA5; tx_enable=1.
   - fifo_rd_en high exactly 1 cycle.
   - tx = 0 | 1,0,1,0,0,1,0,1 | 1, each bit 4 cycles.
   - frame_done pulses once, 42 cycles after leaving IDLE.
2. FIFO holds 0x01,0x02,0x03 back-to-back.
   - Three pops, three frames with fifo_rd_en edges 43 cycles apart.
   - Bytes arrive in order; then IDLE with busy=0 and fifo_rd_en stuck 0 while empty.
3. PARITY_EN=1, byte 0xA5 (four ones).
   - PARITY_ODD=0: parity bit = 0. PARITY_ODD=1: parity bit = 1.
   - Frame lengthens by 4 cycles.
4. STOP_BITS=2, byte 0xFF: stop phase lasts 8 cycles of tx=1 before frame_done.
5. tx_enable deasserted during DATA bit 3 with FIFO non-empty.
   - Frame finishes, then IDLE with no further fifo_rd_en.
   - Re-asserting tx_enable starts the next pop the following cycle.
6. rst_n asserted during DATA bit 5.
   - tx=1, busy=0, fifo_rd_en=0 without waiting for a clk edge.
   - After release, the next queued byte transmits cleanly.
